// File: rtl/ama_riscv_pipe_ctrl.sv
// Pipeline sequencer for the 3-stage IF/ID/EX core: boot sequence, PC select/write,
// stall/clear generation for mispredict flush, load-use stall and JAL redirect.
module ama_riscv_pipe_ctrl #(
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int LOAD_STALL   = 1,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        br_ex,
    input  logic        br_taken_ex,
    input  logic        bp_taken_ex,
    input  logic        jalr_ex,
    input  logic        jal_id,
    input  logic        ld_ex,
    input  logic [4:0]  rd_ex,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic        rs1_use_id,
    input  logic        rs2_use_id,
    output logic [1:0]  pc_sel,
    output logic        pc_we,
    output logic        imem_en,
    output logic        stall_if,
    output logic        stall_id,
    output logic        clear_if,
    output logic        clear_id,
    output logic        clear_ex,
    output logic [15:0] mispred_cnt,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, LDSTALL} state_t;

    localparam logic [1:0] PC_START = 2'b00;
    localparam logic [1:0] PC_INC4  = 2'b01;
    localparam logic [1:0] PC_EX    = 2'b10;
    localparam logic [1:0] PC_JAL   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BOOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_STALL - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       mispred_cnt_q, mispred_cnt_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              mis, luh, mis_inc, stall_inc;

    assign mis = jalr_ex | (br_ex & (br_taken_ex ^ bp_taken_ex));
    assign luh = ld_ex & (rd_ex != 5'd0) &
                 ((rs1_use_id & (rs1_id == rd_ex)) | (rs2_use_id & (rs2_id == rd_ex)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mis_inc   = 1'b0;
        stall_inc = 1'b0;
        pc_sel    = PC_START;
        pc_we     = 1'b0;
        imem_en   = 1'b0;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        clear_if  = 1'b0;
        clear_id  = 1'b0;
        clear_ex  = 1'b0;

        case (state_q)
            BOOT: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                clear_if = 1'b1;
                clear_id = 1'b1;
                clear_ex = 1'b1;
                // Last boot cycle fetches from the start address.
                if (cnt_q == BOOT_LAST) begin
                    pc_we   = 1'b1;
                    imem_en = 1'b1;
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            FLUSH: begin
                clear_if = 1'b1;
                clear_id = 1'b1;
                pc_sel   = PC_INC4;
                pc_we    = 1'b1;
                imem_en  = 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                // RUN and LDSTALL share the priority chain; a redirect aborts a stall.
                if (mis) begin
                    pc_sel   = PC_EX;
                    pc_we    = 1'b1;
                    imem_en  = 1'b1;
                    clear_if = 1'b1;
                    clear_id = 1'b1;
                    mis_inc  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end else if (luh || (state_q == LDSTALL)) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    clear_ex  = 1'b1;
                    stall_inc = 1'b1;
                    if (state_q == LDSTALL) begin
                        if (cnt_q == LOAD_LAST) begin
                            state_d = RUN;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (LOAD_STALL > 1) begin
                        state_d = LDSTALL;
                        cnt_d   = CNT_ONE;
                    end
                end else if (jal_id) begin
                    pc_sel   = PC_JAL;
                    pc_we    = 1'b1;
                    imem_en  = 1'b1;
                    clear_if = 1'b1;
                end else begin
                    pc_sel  = PC_INC4;
                    pc_we   = 1'b1;
                    imem_en = 1'b1;
                end
            end
        endcase

        mispred_cnt_d = (mis_inc && (mispred_cnt_q != 16'hFFFF)) ? mispred_cnt_q + 16'd1
                                                                  : mispred_cnt_q;
        stall_cnt_d   = (stall_inc && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1
                                                                  : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= BOOT;
            cnt_q         <= '0;
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign mispred_cnt = mispred_cnt_q;
    assign stall_cnt   = stall_cnt_q;

endmodule
